// File: rtl/tx_reg_pkg.sv
// tx_reg_pkg: shared widths and FSM state type for the byte-serialising transmit register
package tx_reg_pkg;
    localparam int DATA_W_DEF = 128;
    localparam int BYTE_W_DEF = 8;
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;
endpackage

// File: rtl/tx_reg_flex_counter.sv
// tx_reg_flex_counter: up-counter with synchronous clear that wraps to zero after the rollover value
module tx_reg_flex_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [W-1:0] rollover_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst || clear_i) cnt_q <= '0;
        else if (en_i) cnt_q <= (cnt_q == rollover_i) ? '0 : cnt_q + W'(1);
    end
    assign count_o = cnt_q;
endmodule

// File: rtl/tx_reg.sv
// tx_reg: loads a DATA_W block and offers it MSB-first one BYTE_W byte at a time under valid/ack
module tx_reg
    import tx_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BYTE_W = BYTE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ack,
    output logic              tx_done
);
    localparam int N = DATA_W / BYTE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt;
    logic              load, adv;
    assign load = (state_q == IDLE) && tx_load;
    assign adv  = byte_valid && byte_ack;
    tx_reg_flex_counter #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (load),
        .en_i       (adv),
        .rollover_i (LAST),
        .count_o    (cnt)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end
    always_comb begin
        state_d = (state_q == IDLE) ? (tx_load ? SEND : IDLE) :
                  (state_q == SEND) ? ((adv && cnt == LAST) ? DONE : SEND) : IDLE;
        shift_d = load ? tx_data : adv ? (shift_q << BYTE_W) : shift_q;
    end
    always_comb begin
        tx_ready   = state_q == IDLE;
        byte_valid = state_q == SEND;
        tx_done    = state_q == DONE;
        byte_out   = byte_valid ? shift_q[DATA_W-1 -: BYTE_W] : '0;
    end
endmodule

// File: tb/tb_tx_reg.sv
// tb_tx_reg: cycle-driven random and directed stimulus checked against a byte-queue model
module tb_tx_reg;
    logic         clk = 0;
    logic         rst, tx_load, byte_ack;
    logic [127:0] tx_data;
    logic         tx_ready, byte_valid, tx_done;
    logic [7:0]   byte_out;
    int           total = 0, bad = 0;
    logic [7:0]   q[$];
    bit           m_done = 0;
    int           done_cnt = 0;
    localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_B = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] BLK_D = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    tx_reg dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ack   (byte_ack),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Checks outputs against the model, drives one cycle of inputs, then advances the model.
    task automatic cyc(input bit r, input bit l, input bit a, input logic [127:0] d);
        bit exp_ready, exp_valid;
        @(negedge clk);
        exp_valid = q.size() > 0;
        exp_ready = !exp_valid && !m_done;
        chk("tx_ready", tx_ready, exp_ready);
        chk("byte_valid", byte_valid, exp_valid);
        chk("byte_out", byte_out, exp_valid ? q[0] : 8'h00);
        chk("tx_done", tx_done, m_done);
        if (tx_done) done_cnt++;
        rst = r; tx_load = l; byte_ack = a; tx_data = d;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (exp_ready && l) begin
            for (int i = 0; i < 16; i++) q.push_back(d[127 - 8*i -: 8]);
        end else if (exp_valid && a) begin
            void'(q.pop_front());
            if (q.size() == 0) m_done = 1;
        end
    endtask

    initial begin
        rst = 1; tx_load = 0; byte_ack = 0; tx_data = '0;
        cyc(1, 0, 0, '0);
        cyc(1, 0, 1, BLK_A);
        cyc(0, 0, 1, '0);
        // full-speed block
        done_cnt = 0;
        cyc(0, 1, 1, BLK_A);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, '0);
        chk("done_fast", done_cnt, 1);
        // three idle cycles before each ack
        done_cnt = 0;
        cyc(0, 1, 0, BLK_A);
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 3; k++) cyc(0, 0, 0, '0);
            cyc(0, 0, 1, '0);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, '0);
        chk("done_slow", done_cnt, 1);
        // load pulses during SEND and DONE are ignored
        cyc(0, 1, 0, BLK_B);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, BLK_B);
        cyc(0, 1, 0, BLK_D);
        cyc(0, 1, 1, BLK_D);
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, BLK_D);
        cyc(0, 1, 0, BLK_D);
        cyc(0, 0, 0, '0);
        // mid-block reset after the fifth ack
        done_cnt = 0;
        cyc(0, 1, 0, BLK_A);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, '0);
        cyc(1, 0, 1, '0);
        cyc(0, 0, 1, '0);
        cyc(0, 0, 0, '0);
        chk("done_abort", done_cnt, 0);
        cyc(0, 1, 0, BLK_B);
        for (int i = 0; i < 18; i++) cyc(0, 0, 1, '0);
        // back-to-back blocks, load held high so it is taken on the first ready cycle
        done_cnt = 0;
        cyc(0, 1, 1, BLK_A);
        for (int i = 0; i < 18; i++) cyc(0, 1, 1, BLK_B);
        for (int i = 0; i < 17; i++) cyc(0, 0, 1, '0);
        chk("done_b2b", done_cnt, 2);
        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                {$urandom, $urandom, $urandom, $urandom});
        cyc(0, 0, 0, '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tx_reg.md
TX_REG -- requirements
Module: tx_reg

Interface
REQ-001 Parameter DATA_W, default 128, width of the block loaded for transmission SHALL be DATA_W bits.
REQ-002 Parameter BYTE_W, default 8, width of each transmitted byte SHALL be BYTE_W bits; DATA_W SHALL be a multiple of BYTE_W.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tx_data  input  DATA_W  block to transmit, sampled only on an accepted load.
REQ-006 tx_load  input  1  load request; accepted only when tx_ready=1.
REQ-007 tx_ready  output  1  high only in IDLE; block can accept a load.
REQ-008 byte_out  output  BYTE_W  current byte offered to the downstream transmitter.
REQ-009 byte_valid  output  1  byte_out is valid and held stable until acknowledged.
REQ-010 byte_ack  input  1  downstream has taken byte_out this cycle.
REQ-011 tx_done  output  1  one-cycle pulse after the last byte is acknowledged.

Function
REQ-012 FSM states SHALL be IDLE, SEND and DONE.
REQ-013 IDLE: tx_ready=1, byte_valid=0, tx_done=0; tx_load=1 SHALL capture tx_data into the shift register, clear the byte counter and go to SEND.
REQ-014 Load latency: tx_load sampled at edge N SHALL give byte_valid=1 with the first byte at cycle N+1.
REQ-015 Byte order SHALL be MSB first: byte 0 = tx_data[DATA_W-1 -: BYTE_W], last byte = tx_data[BYTE_W-1:0].
REQ-016 SEND: byte_valid=1 and byte_out SHALL stay constant until a cycle with byte_ack=1.
REQ-017 In SEND, byte_ack=1 SHALL shift the register left by BYTE_W and increment the counter; the next byte SHALL appear the following cycle with byte_valid still 1 (no bubble).
REQ-018 Back-to-back byte_ack on consecutive cycles SHALL advance one byte per cycle.
REQ-019 When byte_ack=1 with the counter at DATA_W/BYTE_W-1 (15 by default), the FSM SHALL go to DONE and the counter SHALL wrap to 0.
REQ-020 DONE SHALL last exactly one cycle with tx_done=1, byte_valid=0 and tx_ready=0, then return to IDLE.
REQ-021 tx_load while tx_ready=0 (SEND or DONE) SHALL be ignored; the in-flight block and tx_data capture SHALL be unaffected.
REQ-022 byte_ack while byte_valid=0 SHALL be ignored.
REQ-023 byte_out SHALL read 0 whenever byte_valid=0.
REQ-024 tx_load and byte_ack high in the same IDLE cycle SHALL act as a load only.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, clear the shift register and counter, and give tx_ready=1, byte_valid=0, byte_out=0, tx_done=0 on the next cycle.
REQ-026 rst SHALL take priority over tx_load and byte_ack; a mid-block reset SHALL abort the block with no tx_done pulse.

Structure
REQ-027 The state enum (IDLE, SEND, DONE) and the BYTE_W/DATA_W defaults SHALL be defined in the shared project package.
REQ-028 The byte counter SHALL be one instance of the team's flex_counter sub-module (rollover value DATA_W/BYTE_W-1, count enable = byte_valid & byte_ack).

Verification
REQ-029 Reset: hold rst=1 for 2 cycles -> tx_ready=1, byte_valid=0, byte_out=0x00, tx_done=0.
REQ-030 Load 128'h00112233_44556677_8899AABB_CCDDEEFF, byte_ack always 1 -> bytes 0x00,0x11,...,0xFF on 16 consecutive cycles, tx_done one cycle after 0xFF, tx_ready the cycle after that.
REQ-031 Same load, byte_ack low for 3 cycles before each ack -> every byte held stable while unacknowledged, order unchanged, exactly one tx_done.
REQ-032 Pulse tx_load with 128'hDEADBEEF... during SEND of 128'h0123... -> remaining bytes still from 128'h0123..., no restart.
REQ-033 Assert rst after the 5th ack -> next cycle IDLE, byte_valid=0, no tx_done; a new load restarts from byte 0.
REQ-034 Two blocks loaded back-to-back (load on the first tx_ready cycle after tx_done) -> 32 bytes in order, two tx_done pulses.
